// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint/cycle-budget sequencer for the single-cycle RV32 core.
// Drives the PC_COUNTER run enable from synchronized board buttons.
module cpu_run_controller #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             step_btn,
  input  logic             cnt_clr,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic [CNT_W-1:0] cycle_limit,
  output logic             run,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StRun   = 2'b01,
    StStep  = 2'b10,
    StBreak = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Button bit order: {step, stop, start}
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       prev_q;
  logic [2:0]       btn_raw;
  logic [2:0]       btn_sync;
  logic [2:0]       btn_pulse;
  logic             start_p;
  logic             stop_p;
  logic             step_p;

  state_e           state_q;
  logic             bp_skip_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bp_match;
  logic             limit_hit;

  assign btn_raw   = {step_btn, stop_btn, start_btn};
  assign btn_sync  = sync_q[SYNC_STAGES-1];
  assign btn_pulse = btn_sync & ~prev_q;
  assign start_p   = btn_pulse[0];
  assign stop_p    = btn_pulse[1];
  assign step_p    = btn_pulse[2];

  // Chains reset high so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 3'b111;
      end
      prev_q <= 3'b111;
    end else begin
      sync_q[0] <= btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= btn_sync;
    end
  end

  assign bp_match = bp_en & (pc == bp_addr) & ~bp_skip_q;

  // Combinational so the breakpointed instruction is blocked in the very cycle it appears.
  always_comb begin
    run = (state_q == StStep) | ((state_q == StRun) & ~bp_match);
  end

  // Also catches a count already at/over the budget on entry: one cycle runs, then halt.
  assign limit_hit = (cycle_limit != '0) & (cnt_q >= (cycle_limit - CntOne));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= StHalt;
      bp_skip_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (run && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntOne;
      end

      if ((state_q == StRun) && run) begin
        bp_skip_q <= 1'b0;
      end

      unique case (state_q)
        StHalt: begin
          if (start_p) begin
            state_q   <= StRun;
            bp_skip_q <= 1'b1;
          end else if (step_p) begin
            state_q <= StStep;
          end
        end
        StRun: begin
          if (stop_p) begin
            state_q <= StHalt;
          end else if (bp_match) begin
            state_q <= StBreak;
          end else if (limit_hit) begin
            state_q <= StHalt;
          end
        end
        StStep: begin
          state_q <= StHalt;
        end
        StBreak: begin
          if (start_p) begin
            state_q   <= StRun;
            bp_skip_q <= 1'b1;
          end else if (step_p) begin
            state_q <= StStep;
          end else if (stop_p) begin
            state_q <= StHalt;
          end
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == StHalt) | (state_q == StBreak);
  assign bp_hit      = (state_q == StBreak);
  assign cycle_count = cnt_q;

endmodule
